mmio_uart_tx: RTL and testbench

//   Memory-mapped transmit port that answers the single-cycle MIPS core's data-memory stores and loads.
//   It buffers bytes written by software in a FIFO and serialises them as 8N1 frames on line tx.
//   It sits beside data memory; the top-level address decoder routes BASE..BASE+0xF here.
//   The bench observes tx to check program output.

---
 rtl/mmio_uart_tx_pkg.sv | 54 +++++
 rtl/mmio_uart_tx_byte_fifo.sv | 71 +++++++
 rtl/mmio_uart_tx.sv | 199 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_pkg
//   Shared definitions for the memory-mapped UART transmitter: register
//   offsets inside the 16-byte window, STATUS/CTRL bit positions, the default
//   window base, the transmit FSM state type and a STATUS packing helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package mmio_uart_tx_pkg;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h0000_7F00;

  // Byte offsets within the register window
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  // CTRL bit positions and reset value (transmitter enabled, irq masked)
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam logic [1:0] CTRL_RESET = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Assemble the STATUS word; unused bits read as zero.
  function automatic logic [31:0] pack_status(
    input logic       full,
    input logic       empty,
    input logic       busy,
    input logic       overflow,
    input logic [3:0] count
  );
    logic [31:0] word;
    word = '0;
    word[STAT_FULL]     = full;
    word[STAT_EMPTY]    = empty;
    word[STAT_BUSY]     = busy;
    word[STAT_OVERFLOW] = overflow;
    word[STAT_COUNT_LSB +: 4] = count;
    return word;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
//   Byte-wide FIFO with a combinational head-of-queue output so the transmit
//   FSM can load its shift register on the same edge it pops.
//   Ports:
//     clock        in   clock, rising-edge state updates
//     reset        in   asynchronous active-low reset (empties the FIFO)
//     i_push       in   write request
//     i_push_data  in   byte to write
//     i_pop        in   read request (ignored while empty)
//     o_head       out  byte at the head of the queue
//     o_full       out  count == DEPTH
//     o_empty      out  count == 0
//     o_count      out  number of stored bytes, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic [7:0]    i_push_data,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_pop_ok  = i_pop && !o_empty;
  // A full FIFO still takes a byte when a pop frees a slot on the same edge.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so wrap-around is free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped UART transmitter for the MIPS data bus. Software stores
//   bytes into TXDATA, they queue in a byte FIFO and are sent as 8N1 frames.
//   Ports:
//     clock      in   single clock, rising-edge state updates
//     reset      in   asynchronous active-low reset
//     mem_addr   in   32  CPU data address
//     mem_wdata  in   32  CPU store data
//     mem_we     in   CPU store strobe, one cycle per store
//     mem_rdata  out  32  load data, combinational from mem_addr
//     tx         out  serial line, idle high
//     irq        out  level interrupt: FIFO drained and line idle
// -----------------------------------------------------------------------------
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = DEFAULT_ADDR_BASE,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Address decode
  logic       w_hit;
  logic [3:0] w_off;
  logic       w_wr_txdata;
  logic       w_wr_status;
  logic       w_wr_ctrl;

  assign w_hit       = (mem_addr[31:4] == ADDR_BASE[31:4]);
  assign w_off       = mem_addr[3:0];
  assign w_wr_txdata = mem_we && w_hit && (w_off == OFF_TXDATA);
  assign w_wr_status = mem_we && w_hit && (w_off == OFF_STATUS);
  assign w_wr_ctrl   = mem_we && w_hit && (w_off == OFF_CTRL);

  // Only the low byte of a store is meaningful; the rest is deliberately ignored.
  logic w_unused_wdata;
  assign w_unused_wdata = ^mem_wdata[31:8];

  // FIFO
  logic [7:0]  w_fifo_head;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [AW:0] w_fifo_count;
  logic        w_pop;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_wr_txdata),
    .i_push_data (mem_wdata[7:0]),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Registers
  logic [1:0] r_ctrl;
  logic       r_overflow;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ctrl     <= CTRL_RESET;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= mem_wdata[1:0];
      end
      // A push into a full FIFO is dropped unless a pop makes room this edge.
      if (w_wr_txdata && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (w_wr_status && mem_wdata[STAT_OVERFLOW]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Transmit FSM
  tx_state_t       r_state;
  logic            r_tx;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_idx;
  logic [CNT_W-1:0] r_clk_cnt;

  logic w_bit_done;
  logic w_busy;

  assign w_bit_done = (r_clk_cnt == CNT_LAST);
  assign w_busy     = (r_state != ST_IDLE);

  // A new frame starts from IDLE, or straight out of the last STOP cycle so
  // consecutive frames are sent without an idle gap.
  assign w_pop = r_ctrl[CTRL_TX_EN] && !w_fifo_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_clk_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx      <= 1'b1;
          r_clk_cnt <= '0;
          if (w_pop) begin
            r_shift <= w_fifo_head;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_state   <= ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_bit_done) begin
            r_clk_cnt <= '0;
            if (w_pop) begin
              r_shift <= w_fifo_head;
              r_tx    <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Outputs
  assign tx  = r_tx;
  assign irq = r_ctrl[CTRL_IRQ_EN] && w_fifo_empty && !w_busy;

  always_comb begin
    mem_rdata = '0;
    if (w_hit) begin
      case (w_off)
        OFF_STATUS: mem_rdata = pack_status(w_fifo_full, w_fifo_empty, w_busy,
                                            r_overflow, 4'(w_fifo_count));
        OFF_CTRL:   mem_rdata = {30'b0, r_ctrl};
        default:    mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_TXDATA = BASE;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_CTRL   = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;
  localparam logic [31:0] A_OUT    = BASE + 32'h10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mmio_uart_tx #(
    .ADDR_BASE    (BASE),
    .FIFO_DEPTH   (8),
    .CLKS_PER_BIT (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the store edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_we    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mem_we    = 1'b0;
    mem_wdata = '0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    #1;
    d = mem_rdata;
  endtask

  // Called on the falling edge of frame cycle 0; samples 40 cycles and
  // returns on the falling edge of cycle 40.
  task automatic recv_frame(output logic [7:0] b, output logic frame_ok,
                            output logic busy_ok, output logic irq_high);
    logic [39:0] line;
    logic [3:0]  s;
    b        = '0;
    busy_ok  = 1'b1;
    irq_high = 1'b0;
    mem_addr = A_STATUS;
    for (int c = 0; c < 40; c++) begin
      #1;
      line[c] = tx;
      if (mem_rdata[2] !== 1'b1) busy_ok = 1'b0;
      if (irq !== 1'b0) irq_high = 1'b1;
      @(negedge clock);
    end
    frame_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s = line[k*4 +: 4];
      if (s !== {4{s[0]}}) frame_ok = 1'b0;
      if (k >= 1 && k <= 8) b[k-1] = s[0];
    end
    if (line[3:0] !== 4'h0 || line[39:36] !== 4'hF) frame_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    logic        fok, bok, irqh, line_ok;

    // ---- 1. reset state ----
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    load(A_STATUS, rd);  check("rst_status", rd, 32'h0000_0002);
    load(A_CTRL, rd);    check("rst_ctrl", rd, 32'h1);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    load(A_TXDATA, rd);  check("txdata_reads_zero", rd, 32'h0);
    load(A_RSVD, rd);    check("rsvd_reads_zero", rd, 32'h0);
    load(A_OUT, rd);     check("outside_reads_zero", rd, 32'h0);
    @(negedge clock);
    store(A_OUT, 32'h99);
    store(A_RSVD, 32'hFF);
    load(A_STATUS, rd);  check("outside_store_ignored", rd, 32'h0000_0002);
    load(A_CTRL, rd);    check("rsvd_store_ignored", rd, 32'h1);
    @(negedge clock);

    // ---- 2. single frame 0x41 ----
    store(A_TXDATA, 32'h41);
    #1;
    check("t2_tx_before_pop", 32'(tx), 32'd1);
    @(negedge clock);
    recv_frame(b, fok, bok, irqh);
    check("t2_byte", 32'(b), 32'h41);
    check("t2_framing", 32'(fok), 32'd1);
    check("t2_busy", 32'(bok), 32'd1);
    load(A_STATUS, rd);  check("t2_idle_status", rd, 32'h0000_0002);
    check("t2_idle_tx", 32'(tx), 32'd1);
    @(negedge clock);

    // ---- 3. overflow then drain 8 frames ----
    store(A_CTRL, 32'h0);
    for (int i = 0; i < 10; i++) store(A_TXDATA, 32'h10 + i);
    load(A_STATUS, rd);  check("t3_full_ovf", rd, 32'h0000_0809);
    @(negedge clock);
    store(A_CTRL, 32'h1);
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      recv_frame(b, fok, bok, irqh);
      check($sformatf("t3_byte%0d", i), 32'(b), 32'h10 + i);
      check($sformatf("t3_framing%0d", i), 32'(fok), 32'd1);
    end
    load(A_STATUS, rd);  check("t3_drained_ovf", rd, 32'h0000_000A);
    check("t3_idle_tx", 32'(tx), 32'd1);
    @(negedge clock);
    store(A_STATUS, 32'h8);
    load(A_STATUS, rd);  check("t3_ovf_cleared", rd, 32'h0000_0002);
    @(negedge clock);

    // ---- 4. irq ----
    store(A_CTRL, 32'h3);
    #1;
    check("t4_irq_idle", 32'(irq), 32'd1);
    @(negedge clock);
    store(A_TXDATA, 32'h55);
    #1;
    check("t4_irq_queued", 32'(irq), 32'd0);
    @(negedge clock);
    recv_frame(b, fok, bok, irqh);
    check("t4_byte", 32'(b), 32'h55);
    check("t4_irq_during_frame", 32'(irqh), 32'd0);
    #1;
    check("t4_irq_after_stop", 32'(irq), 32'd1);
    @(negedge clock);
    store(A_CTRL, 32'h1);

    // ---- 5. reset mid-frame ----
    store(A_TXDATA, 32'h01);
    store(A_TXDATA, 32'h02);
    repeat (15) @(negedge clock);
    load(A_STATUS, rd);  check("t5_pre_reset_status", rd, 32'h0000_0104);
    check("t5_tx_cycle15", 32'(tx), 32'd0);
    reset = 1'b0;
    #1;
    check("t5_tx_reset", 32'(tx), 32'd1);
    load(A_STATUS, rd);  check("t5_status_reset", rd, 32'h0000_0002);
    load(A_CTRL, rd);    check("t5_ctrl_reset", rd, 32'h1);
    @(negedge clock);
    reset = 1'b1;
    line_ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      #1;
      if (tx !== 1'b1) line_ok = 1'b0;
    end
    check("t5_no_residual_frame", 32'(line_ok), 32'd1);
    @(negedge clock);

    // ---- 6. push on the same edge as the IDLE pop while full ----
    store(A_CTRL, 32'h0);
    for (int i = 0; i < 8; i++) store(A_TXDATA, 32'h60 + i);
    load(A_STATUS, rd);  check("t6_full", rd, 32'h0000_0801);
    @(negedge clock);
    store(A_CTRL, 32'h1);
    store(A_TXDATA, 32'h68);
    load(A_STATUS, rd);  check("t6_push_pop_full", rd, 32'h0000_0805);
    for (int i = 0; i < 9; i++) begin
      recv_frame(b, fok, bok, irqh);
      check($sformatf("t6_byte%0d", i), 32'(b), 32'h60 + i);
      check($sformatf("t6_framing%0d", i), 32'(fok), 32'd1);
    end
    load(A_STATUS, rd);  check("t6_drained", rd, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
